ucsbece154a_memarb: RTL and testbench
=====================================

# ucsbece154a_memarb

Two-requester arbiter for the single-port unified instruction/data memory of the multicycle RISC-V processor. It shares the memory between the CPU port and a debug/program-loader port. Each transaction is sequenced as issue, fixed-latency wait, then a one-cycle acknowledge. Contention is resolved round-robin.

## Interface
Parameters:
- MEM_LAT, 1: cycles from the memory issue cycle to read data valid on mem_rd_i. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  CPU request; held high until cpu_ack_o.
- cpu_we_i  in  1  CPU write enable (1 = write, 0 = read).
- cpu_adr_i  in  32  CPU byte address.
- cpu_wd_i  in  32  CPU write data.
- cpu_ack_o  out  1  one-cycle completion pulse to CPU.
- cpu_rd_o  out  32  CPU read data; holds the last CPU read result.
- dbg_req_i / dbg_we_i / dbg_adr_i / dbg_wd_i  in  1/1/32/32  debug port; same semantics as the CPU port.
- dbg_ack_o  out  1  debug completion pulse.
- dbg_rd_o  out  32  debug read data; holds the last debug read result.
- mem_en_o  out  1  memory access strobe; high only in the ISSUE cycle.
- mem_we_o  out  1  memory write strobe; high only in an ISSUE cycle of a write.
- mem_adr_o  out  32  latched address of the current or most recent transaction.
- mem_wd_o  out  32  latched write data.
- mem_rd_i  in  32  memory read data, valid MEM_LAT cycles after ISSUE.
- busy_o  out  1  high whenever the state is not IDLE.
- grant_o  out  1  owner of the current transaction (0 = CPU, 1 = debug); holds its value when idle.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If neither requester is asserting, remain in IDLE.
  - If exactly one requests, grant it.
  - If both request, grant the one not equal to last_grant.
  - On a grant, latch we/adr/wd and the owner into internal registers, update last_grant, and go to ISSUE.
- ISSUE:
  - mem_en_o=1; mem_we_o=latched we.
  - A write goes to DONE.
  - A read goes to WAIT with cnt=MEM_LAT.
- WAIT:
  - cnt decrements each cycle.
  - In the cycle where cnt==1, mem_rd_i is captured into the owner's rd register (cpu_rd_o or dbg_rd_o only), then the FSM goes to DONE.
- DONE:
  - The owner's ack is high for exactly this cycle.
  - Requests are ignored; next state is IDLE.
- The non-owner's ack and rd register are never disturbed.
- Writes never modify cpu_rd_o or dbg_rd_o.
- Requester rule: drop req in the cycle after ack, or the req is treated as a new transaction in IDLE.
- If req is deasserted before ack, the transaction still completes and ack still pulses.
- Changes to adr/wd/we after the grant are ignored; the latched values are used.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE, last_grant=1 (so the CPU wins the first contention), and cnt=0.
  - All outputs are 0: acks, mem_en_o, mem_we_o, mem_adr_o, mem_wd_o, cpu_rd_o, dbg_rd_o, busy_o, grant_o.
- Reset mid-transaction aborts it: mem_en_o/mem_we_o drop without waiting for a clock edge, and no ack is issued.
- All outputs are registered; there is no combinational path from any *_req_i to any output.
- Read with request seen in IDLE cycle 0: ISSUE is cycle 1, WAIT covers cycles 2..1+MEM_LAT, and ack is in cycle 2+MEM_LAT.
- Write with request seen in cycle 0: ISSUE is cycle 1, ack is in cycle 2.
- Minimum spacing between ISSUE cycles is MEM_LAT+3 cycles for reads and 3 cycles for writes, because IDLE always lasts at least one cycle.
- Continuous contention strictly alternates CPU, DBG, CPU, ... with no starvation.
- cnt is 4 bits wide; MEM_LAT=15 must work without wrap.

## Test plan
- Reset: hold reset=0 with random inputs -> all outputs 0 and busy_o=0. Release reset, then CPU read adr=0x10, MEM_LAT=1, mem_rd_i=0xDEADBEEF -> mem_en_o=1 in cycle 1, cpu_ack_o=1 in cycle 3, cpu_rd_o=0xDEADBEEF, dbg_rd_o=0.
- Write: DBG write adr=0x20, wd=0x12345678 -> one cycle with mem_en_o=mem_we_o=1, mem_adr_o=0x20, mem_wd_o=0x12345678; dbg_ack_o=1 two cycles after the request; cpu_rd_o/dbg_rd_o unchanged.
- Contention: both requests held continuously for 4 transactions -> grant_o sequence 0,1,0,1, and each ack goes only to the matching owner.
- Latency: MEM_LAT=15 read -> ack exactly 17 cycles after the IDLE sample. Data changing on mem_rd_i before cycle 16 is not captured.
- Reset mid-operation: assert reset during WAIT of a CPU read -> mem_en_o=0 and busy_o=0 immediately, no cpu_ack_o. After release, a new DBG read completes normally.
- Protocol edge: CPU drops req during WAIT and changes adr after the grant -> ack is still pulsed, and the original latched adr is seen on mem_adr_o.

Source files
------------

// File: rtl/ucsbece154a_memarb_if.sv
// Bus bundle for the two-requester memory arbiter: CPU port, debug port and memory side.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface ucsbece154a_memarb_if;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_adr_i;
  logic [31:0] cpu_wd_i;
  logic        cpu_ack_o;
  logic [31:0] cpu_rd_o;

  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [31:0] dbg_adr_i;
  logic [31:0] dbg_wd_i;
  logic        dbg_ack_o;
  logic [31:0] dbg_rd_o;

  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  logic        busy_o;
  logic        grant_o;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_adr_i, cpu_wd_i,
    output cpu_ack_o, cpu_rd_o,
    input  dbg_req_i, dbg_we_i, dbg_adr_i, dbg_wd_i,
    output dbg_ack_o, dbg_rd_o,
    output mem_en_o, mem_we_o, mem_adr_o, mem_wd_o,
    input  mem_rd_i,
    output busy_o, grant_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_adr_i, cpu_wd_i,
    input  cpu_ack_o, cpu_rd_o,
    output dbg_req_i, dbg_we_i, dbg_adr_i, dbg_wd_i,
    input  dbg_ack_o, dbg_rd_o,
    input  mem_en_o, mem_we_o, mem_adr_o, mem_wd_o,
    output mem_rd_i,
    input  busy_o, grant_o
  );
endinterface

// File: rtl/ucsbece154a_memarb.sv
// Round-robin arbiter sharing a single-port fixed-latency memory between CPU and debug ports.
// Each transaction runs IDLE -> ISSUE -> (WAIT x MEM_LAT for reads) -> DONE.
module ucsbece154a_memarb #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  ucsbece154a_memarb_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cpu_rd_q, cpu_rd_d;
  logic [31:0] dbg_rd_q, dbg_rd_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dbg_ack_q, dbg_ack_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;
  logic        gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      wd_q         <= '0;
      cnt_q        <= '0;
      cpu_rd_q     <= '0;
      dbg_rd_q     <= '0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      cpu_rd_q     <= cpu_rd_d;
      dbg_rd_q     <= dbg_rd_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    adr_d        = adr_q;
    wd_d         = wd_q;
    cnt_d        = cnt_q;
    cpu_rd_d     = cpu_rd_q;
    dbg_rd_d     = dbg_rd_q;
    gnt          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req_i || bus.dbg_req_i) begin
          if (bus.cpu_req_i && bus.dbg_req_i) gnt = ~last_grant_q;
          else                                gnt = bus.dbg_req_i;
          owner_d      = gnt;
          last_grant_d = gnt;
          we_d         = gnt ? bus.dbg_we_i  : bus.cpu_we_i;
          adr_d        = gnt ? bus.dbg_adr_i : bus.cpu_adr_i;
          wd_d         = gnt ? bus.dbg_wd_i  : bus.cpu_wd_i;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = LAT4;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // cnt_q==0 cannot occur in WAIT; treat it as final to avoid a 16-cycle wrap
        if (cnt_q <= 4'd1) begin
          if (owner_q) dbg_rd_d = bus.mem_rd_i;
          else         cpu_rd_d = bus.mem_rd_i;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered from the next state so they line up with the state they describe
    mem_en_d  = (state_d == S_ISSUE);
    mem_we_d  = (state_d == S_ISSUE) && we_d;
    busy_d    = (state_d != S_IDLE);
    cpu_ack_d = (state_d == S_DONE) && !owner_d;
    dbg_ack_d = (state_d == S_DONE) &&  owner_d;
  end

  assign bus.cpu_ack_o = cpu_ack_q;
  assign bus.cpu_rd_o  = cpu_rd_q;
  assign bus.dbg_ack_o = dbg_ack_q;
  assign bus.dbg_rd_o  = dbg_rd_q;
  assign bus.mem_en_o  = mem_en_q;
  assign bus.mem_we_o  = mem_we_q;
  assign bus.mem_adr_o = adr_q;
  assign bus.mem_wd_o  = wd_q;
  assign bus.busy_o    = busy_q;
  assign bus.grant_o   = owner_q;

endmodule

// File: tb/tb_ucsbece154a_memarb.sv
// Directed bench for ucsbece154a_memarb: a table of single-requester transactions plus
// hand-written contention, long-latency, reset-abort and protocol-edge sequences.
module tb_ucsbece154a_memarb;

  logic clk;
  logic reset;

  ucsbece154a_memarb_if a ();
  ucsbece154a_memarb_if b ();

  ucsbece154a_memarb #(.MEM_LAT(1))  dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  ucsbece154a_memarb #(.MEM_LAT(15)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));

  localparam int unsigned LAT_A = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int unsigned exp_ack_cyc;
    logic [31:0] exp_cpu_rd;
    logic [31:0] exp_dbg_rd;
  } vec_t;

  vec_t vecs [6];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    a.cpu_req_i = 0; a.cpu_we_i = 0; a.cpu_adr_i = '0; a.cpu_wd_i = '0;
    a.dbg_req_i = 0; a.dbg_we_i = 0; a.dbg_adr_i = '0; a.dbg_wd_i = '0;
    a.mem_rd_i  = '0;
    b.cpu_req_i = 0; b.cpu_we_i = 0; b.cpu_adr_i = '0; b.cpu_wd_i = '0;
    b.dbg_req_i = 0; b.dbg_we_i = 0; b.dbg_adr_i = '0; b.dbg_wd_i = '0;
    b.mem_rd_i  = '0;
  endtask

  // One transaction on instance a; cycle 0 is the IDLE cycle in which the request is first seen.
  task automatic run_txn(input vec_t v, input string nm);
    int unsigned en_cyc, en_cnt, ack_cyc, bad_ack;
    logic        we_iss, g_iss;
    logic [31:0] adr_iss, wd_iss;
    bit          done;
    en_cyc = 0; en_cnt = 0; ack_cyc = 0; bad_ack = 0; done = 0;
    we_iss = 0; g_iss = 0; adr_iss = '0; wd_iss = '0;
    @(posedge clk); #1;
    if (v.dbg) begin
      a.dbg_req_i = 1; a.dbg_we_i = v.we; a.dbg_adr_i = v.adr; a.dbg_wd_i = v.wd;
    end else begin
      a.cpu_req_i = 1; a.cpu_we_i = v.we; a.cpu_adr_i = v.adr; a.cpu_wd_i = v.wd;
    end
    for (int k = 0; k < 40 && !done; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      a.mem_rd_i = (k == 1 + LAT_A) ? v.rdata : (32'h5555_0000 + 32'(k));
      @(negedge clk);
      if (a.mem_en_o) begin
        en_cnt++; en_cyc = k;
        we_iss = a.mem_we_o; adr_iss = a.mem_adr_o; wd_iss = a.mem_wd_o; g_iss = a.grant_o;
      end
      if (v.dbg ? a.cpu_ack_o : a.dbg_ack_o) bad_ack++;
      if (v.dbg ? a.dbg_ack_o : a.cpu_ack_o) begin
        ack_cyc = k; done = 1;
        a.cpu_req_i = 0; a.dbg_req_i = 0;
      end
    end
    chk({nm, "_en_cycle"}, en_cyc, 1);
    chk({nm, "_en_count"}, en_cnt, 1);
    chk({nm, "_we_issue"}, {31'b0, we_iss}, {31'b0, v.we});
    chk({nm, "_adr_issue"}, adr_iss, v.adr);
    chk({nm, "_wd_issue"}, wd_iss, v.wd);
    chk({nm, "_grant_issue"}, {31'b0, g_iss}, {31'b0, v.dbg});
    chk({nm, "_ack_cycle"}, ack_cyc, v.exp_ack_cyc);
    chk({nm, "_other_ack"}, bad_ack, 0);
    @(posedge clk); #1;
    a.mem_rd_i = 32'h5555_FFFF;
    @(negedge clk);
    chk({nm, "_busy_idle"}, {31'b0, a.busy_o}, 0);
    chk({nm, "_grant_hold"}, {31'b0, a.grant_o}, {31'b0, v.dbg});
    chk({nm, "_cpu_rd"}, a.cpu_rd_o, v.exp_cpu_rd);
    chk({nm, "_dbg_rd"}, a.dbg_rd_o, v.exp_dbg_rd);
    a.cpu_we_i = 0; a.dbg_we_i = 0;
  endtask

  initial begin
    int unsigned idx, en_cyc, ack_cyc, acks;
    logic        exp_g;
    logic [31:0] adr_at_ack;
    bit          done, we_seen;
    vec_t        v;

    //            dbg   we    adr            wd             rdata          ack cpu_rd         dbg_rd
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 2, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0024, 32'h0000_0000, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 32'h0000_0000, 2, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0BAD_C0DE, 3, 32'h0BAD_C0DE, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0028, 32'hFFFF_0000, 32'h0000_0000, 2, 32'h0BAD_C0DE, 32'hCAFE_F00D};

    // Reset held with random inputs
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      a.cpu_req_i = 1'($urandom); a.cpu_we_i = 1'($urandom); a.cpu_adr_i = $urandom; a.cpu_wd_i = $urandom;
      a.dbg_req_i = 1'($urandom); a.dbg_we_i = 1'($urandom); a.dbg_adr_i = $urandom; a.dbg_wd_i = $urandom;
      a.mem_rd_i  = $urandom;
    end
    @(negedge clk);
    chk("rst_cpu_ack", {31'b0, a.cpu_ack_o}, 0);
    chk("rst_dbg_ack", {31'b0, a.dbg_ack_o}, 0);
    chk("rst_mem_en",  {31'b0, a.mem_en_o}, 0);
    chk("rst_mem_we",  {31'b0, a.mem_we_o}, 0);
    chk("rst_mem_adr", a.mem_adr_o, 0);
    chk("rst_mem_wd",  a.mem_wd_o, 0);
    chk("rst_cpu_rd",  a.cpu_rd_o, 0);
    chk("rst_dbg_rd",  a.dbg_rd_o, 0);
    chk("rst_busy",    {31'b0, a.busy_o}, 0);
    chk("rst_grant",   {31'b0, a.grant_o}, 0);
    chk("rst_b_busy",  {31'b0, b.busy_o}, 0);
    idle_inputs();
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Continuous contention; last owner was debug, so the CPU goes first
    @(posedge clk); #1;
    a.cpu_req_i = 1; a.cpu_adr_i = 32'h0000_0100;
    a.dbg_req_i = 1; a.dbg_adr_i = 32'h0000_0200;
    a.mem_rd_i  = 32'h7777_0000;
    idx = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (a.cpu_ack_o || a.dbg_ack_o) begin
        exp_g = idx[0];
        chk($sformatf("cont%0d_cpu_ack", idx), {31'b0, a.cpu_ack_o}, {31'b0, ~exp_g});
        chk($sformatf("cont%0d_dbg_ack", idx), {31'b0, a.dbg_ack_o}, {31'b0, exp_g});
        chk($sformatf("cont%0d_grant", idx), {31'b0, a.grant_o}, {31'b0, exp_g});
        idx++;
        if (idx == 4) begin a.cpu_req_i = 0; a.dbg_req_i = 0; done = 1; end
      end
    end
    chk("cont_txn_count", idx, 4);
    idle_inputs();
    repeat (2) @(posedge clk);

    // MEM_LAT=15 read on instance b; only cycle 16 carries the real data
    @(posedge clk); #1;
    b.cpu_req_i = 1; b.cpu_adr_i = 32'h0000_0100;
    en_cyc = 0; ack_cyc = 0; done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      b.mem_rd_i = (k == 16) ? 32'h600D_DA7A : (32'h4444_0000 + 32'(k));
      @(negedge clk);
      if (b.mem_en_o) en_cyc = k;
      if (b.cpu_ack_o) begin ack_cyc = k; done = 1; b.cpu_req_i = 0; end
    end
    chk("lat15_en_cycle", en_cyc, 1);
    chk("lat15_ack_cycle", ack_cyc, 17);
    chk("lat15_cpu_rd", b.cpu_rd_o, 32'h600D_DA7A);
    chk("lat15_dbg_rd", b.dbg_rd_o, 0);
    idle_inputs();
    repeat (2) @(posedge clk);

    // Reset during WAIT of a CPU read on instance a
    @(posedge clk); #1;
    a.cpu_req_i = 1; a.cpu_adr_i = 32'h0000_0044; a.mem_rd_i = 32'h9999_9999;
    @(negedge clk);
    @(negedge clk);
    chk("abort_issue_en", {31'b0, a.mem_en_o}, 1);
    @(negedge clk);
    chk("abort_wait_busy", {31'b0, a.busy_o}, 1);
    reset = 0; a.cpu_req_i = 0;
    #1;
    chk("abort_busy", {31'b0, a.busy_o}, 0);
    chk("abort_mem_en", {31'b0, a.mem_en_o}, 0);
    chk("abort_cpu_rd", a.cpu_rd_o, 0);
    @(negedge clk);
    reset = 1;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a.cpu_ack_o || a.dbg_ack_o) acks++;
    end
    chk("abort_no_ack", acks, 0);
    v = '{1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h1357_2468, 3, 32'h0000_0000, 32'h1357_2468};
    run_txn(v, "post_rst");

    // CPU changes address after grant and drops req during WAIT
    @(posedge clk); #1;
    a.cpu_req_i = 1; a.cpu_we_i = 0; a.cpu_adr_i = 32'h0000_0050;
    ack_cyc = 0; adr_at_ack = '0; done = 0; we_seen = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == 1) begin a.cpu_adr_i = 32'hFFFF_FFF0; a.cpu_wd_i = 32'h0BAD_0BAD; a.cpu_we_i = 1; end
      if (k == 2) a.cpu_req_i = 0;
      a.mem_rd_i = (k == 1 + LAT_A) ? 32'h2468_ACE0 : 32'h3333_0000;
      @(negedge clk);
      if (a.mem_we_o) we_seen = 1;
      if (a.cpu_ack_o) begin ack_cyc = k; adr_at_ack = a.mem_adr_o; done = 1; end
    end
    chk("edge_ack_cycle", ack_cyc, 3);
    chk("edge_latched_adr", adr_at_ack, 32'h0000_0050);
    chk("edge_no_write", {31'b0, we_seen}, 0);
    chk("edge_cpu_rd", a.cpu_rd_o, 32'h2468_ACE0);
    chk("edge_dbg_rd", a.dbg_rd_o, 32'h1357_2468);
    idle_inputs();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
